// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_reader
// Description : Sweeps a ROM address range, streams each word out on a
//               valid/ready handshake and reports the XOR of delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_reader #(
  parameter int D = 8,
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [D-1:0] base_i,
  input  logic [D:0]   len_i,
  output logic [D-1:0] addr_o,
  output logic         rden_o,
  input  logic [W-1:0] rom_dato_i,
  output logic [W-1:0] dato_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] xor_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [D-1:0] c_ADDR_ONE  = {{(D-1){1'b0}}, 1'b1};
  localparam logic [D:0]   c_COUNT_ONE = {{D{1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_next;
  logic [D-1:0]   r_addr;
  logic [D:0]     r_count;
  logic [W-1:0]   r_dato;
  logic [W-1:0]   r_xor;
  logic           w_handshake;

  assign w_handshake = (r_state == S_HOLD) && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_dato  <= '0;
      r_xor   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr  <= base_i;
            r_count <= len_i;
            r_xor   <= '0;
          end
        end
        S_READ: r_dato <= rom_dato_i;
        S_HOLD: begin
          if (w_handshake) begin
            r_xor   <= r_xor ^ r_dato;
            r_addr  <= r_addr + c_ADDR_ONE;   // natural wrap at 2**D
            r_count <= r_count - c_COUNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    rden_o  = 1'b0;
    valid_o = 1'b0;
    done_o  = 1'b0;
    busy_o  = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_next = (len_i == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rden_o = 1'b1;
        w_next = S_HOLD;
      end
      S_HOLD: begin
        valid_o = 1'b1;
        if (w_handshake) begin
          w_next = (r_count == c_COUNT_ONE) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign addr_o = r_addr;
  assign dato_o = r_dato;
  assign xor_o  = r_xor;

endmodule
`default_nettype wire
